// File: rtl/ser_pkg.sv
// Shared types and counter widths for the bit serializer.
package ser_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} ser_state_t;

    localparam int MAX_WIDTH = 32;
    localparam int MAX_GAP   = 255;
    localparam int CNT_W     = $clog2(MAX_WIDTH);
    localparam int GAP_W     = $clog2(MAX_GAP + 1);

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry valid/ready holding buffer in front of the shift register.
module ser_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    input  logic             take,
    output logic             hold_valid,
    output logic [WIDTH-1:0] hold_data
);

    // take is only asserted while full and a load only happens while empty,
    // so the two never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (s_valid && s_ready) begin
            hold_valid <= 1'b1;
            hold_data  <= s_data;
        end else if (take) begin
            hold_valid <= 1'b0;
        end
    end

    assign s_ready = !hold_valid;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: valid/ready word input, one bit per enabled clock out.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_BIT   = 1'b0,
    parameter int   GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             bit_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             sof,
    output logic             word_done
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    ser_state_t       state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic             sof_flag, sof_n;
    logic             done_q, done_n;
    logic             take;
    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;

    ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .take      (take),
        .hold_valid(hold_valid),
        .hold_data (hold_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            sof_flag <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            gap_cnt  <= gap_cnt_n;
            sof_flag <= sof_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        sof_n     = sof_flag;
        done_n    = 1'b0;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    state_n   = SHIFT;
                    shreg_n   = hold_data;
                    bit_cnt_n = LAST_BIT;
                    sof_n     = 1'b1;
                    take      = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    sof_n = 1'b0;
                    if (bit_cnt != '0) begin
                        shreg_n   = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
                        bit_cnt_n = bit_cnt - 1'b1;
                    end else begin
                        done_n = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_n   = GAP;
                            gap_cnt_n = GAP_LOAD;
                        end else if (hold_valid) begin
                            // Back-to-back word: reload with no idle bit in between.
                            shreg_n   = hold_data;
                            bit_cnt_n = LAST_BIT;
                            sof_n     = 1'b1;
                            take      = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                if (bit_en) begin
                    if (gap_cnt == '0) begin
                        if (hold_valid) begin
                            state_n   = SHIFT;
                            shreg_n   = hold_data;
                            bit_cnt_n = LAST_BIT;
                            sof_n     = 1'b1;
                            take      = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        gap_cnt_n = gap_cnt - 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from state registers only; inputs never reach them directly.
    assign ser_valid = (state == SHIFT);
    assign ser_out   = ser_valid ? ((MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0]) : IDLE_BIT;
    assign sof       = ser_valid && sof_flag;
    assign word_done = done_q;

endmodule
